// File: rtl/seq_alu_pkg.sv
// Shared types for the multi-cycle ALU: decoded operation, alu_op field encoding
// and FSM states.
package seq_alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA,
    ALU_XOR,
    ALU_OR,
    ALU_AND,
    ALU_SLT,
    ALU_SLTU
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    ALU_OP_MEM    = 2'b00,
    ALU_OP_BRANCH = 2'b01,
    ALU_OP_ARITH  = 2'b10,
    ALU_OP_RSVD   = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_e;

  function automatic logic is_shift(alu_ctrl_e ctrl);
    return (ctrl == ALU_SLL) || (ctrl == ALU_SRL) || (ctrl == ALU_SRA);
  endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Issue/writeback handshake bundle for seq_alu_unit; master is the pipeline,
// slave is the ALU.
interface seq_alu_if #(parameter int XLEN = 32);
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      alu_op;
    logic [2:0]      funct3;
    logic            op5;
    logic            funct7;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            neg;

    modport master (
        output in_valid, alu_op, funct3, op5, funct7, a, b, out_ready,
        input  in_ready, out_valid, result, zero, neg
    );

    modport slave (
        input  in_valid, alu_op, funct3, op5, funct7, a, b, out_ready,
        output in_ready, out_valid, result, zero, neg
    );
endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational ALU-control decode: alu_op/funct3/op5/funct7 to a decoded
// operation. Shared with the single-cycle core.
module alu_ctrl_decode
    import seq_alu_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7,
    output alu_ctrl_e  ctrl
);

    always_comb begin
        // NOTE: default assigned first so every path drives ctrl and no latch is inferred.
        ctrl = ALU_ADD;
        case (alu_op)
            ALU_OP_BRANCH: begin
                case (funct3)
                    3'b000, 3'b001: ctrl = ALU_SUB;
                    3'b100, 3'b101: ctrl = ALU_SLT;
                    3'b110, 3'b111: ctrl = ALU_SLTU;
                    default:        ctrl = ALU_ADD;
                endcase
            end
            ALU_OP_ARITH: begin
                case (funct3)
                    3'b000:  ctrl = (op5 && funct7) ? ALU_SUB : ALU_ADD;
                    3'b001:  ctrl = ALU_SLL;
                    3'b010:  ctrl = ALU_SLT;
                    3'b011:  ctrl = ALU_SLTU;
                    3'b100:  ctrl = ALU_XOR;
                    3'b101:  ctrl = funct7 ? ALU_SRA : ALU_SRL;
                    3'b110:  ctrl = ALU_OR;
                    default: ctrl = ALU_AND;
                endcase
            end
            default: ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/seq_alu_unit.sv
// Multi-cycle ALU: single-cycle ops complete in one cycle, shifts iterate
// SHIFT_STEP bits per cycle; valid/ready on both issue and writeback sides.
module seq_alu_unit
    import seq_alu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic clk,
    input  logic rst_n,
    seq_alu_if.slave bus
);

    localparam int SHW = $clog2(XLEN);
    localparam logic [SHW:0] STEP = (SHW + 1)'(SHIFT_STEP);

    state_e          state_q, state_d;
    alu_ctrl_e       ctrl, kind_q, kind_d;
    logic [XLEN-1:0] work_q, work_d, shifted, alu_res;
    logic [XLEN-1:0] result_q, result_d;
    logic [SHW-1:0]  rem_q, rem_d, step, shamt;
    logic            zero_q, zero_d, neg_q, neg_d, load, accept;

    alu_ctrl_decode u_decode (
        .alu_op (bus.alu_op),
        .funct3 (bus.funct3),
        .op5    (bus.op5),
        .funct7 (bus.funct7),
        .ctrl   (ctrl)
    );

    assign shamt        = bus.b[SHW-1:0];
    assign bus.in_ready = rst_n && ((state_q == ST_IDLE) || (state_q == ST_DONE && bus.out_ready));
    assign accept       = bus.in_valid && bus.in_ready;
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.result   = result_q;
    assign bus.zero     = zero_q;
    assign bus.neg      = neg_q;

    // Single-cycle result; a shift reaching this path has shamt 0 and yields a.
    always_comb begin
        alu_res = bus.a + bus.b;
        case (ctrl)
            ALU_SUB:  alu_res = bus.a - bus.b;
            ALU_XOR:  alu_res = bus.a ^ bus.b;
            ALU_OR:   alu_res = bus.a | bus.b;
            ALU_AND:  alu_res = bus.a & bus.b;
            ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
            ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, bus.a < bus.b};
            ALU_SLL, ALU_SRL, ALU_SRA: alu_res = bus.a;
            default:  alu_res = bus.a + bus.b;
        endcase
    end

    always_comb begin
        step = ({1'b0, rem_q} < STEP) ? rem_q : STEP[SHW-1:0];
        case (kind_q)
            ALU_SLL: shifted = work_q << step;
            ALU_SRA: shifted = $signed(work_q) >>> step;
            default: shifted = work_q >> step;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        rem_d    = rem_q;
        kind_d   = kind_q;
        result_d = result_q;
        load     = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (state_q == ST_DONE && bus.out_ready) state_d = ST_IDLE;
                if (accept) begin
                    if (is_shift(ctrl) && shamt != '0) begin
                        work_d  = bus.a;
                        rem_d   = shamt;
                        kind_d  = ctrl;
                        state_d = ST_SHIFT;
                    end else begin
                        result_d = alu_res;
                        load     = 1'b1;
                        state_d  = ST_DONE;
                    end
                end
            end
            ST_SHIFT: begin
                work_d = shifted;
                rem_d  = rem_q - step;
                if (rem_q == step) begin
                    result_d = shifted;
                    load     = 1'b1;
                    state_d  = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Flags follow the result only when a new result is loaded.
        zero_d = load ? (result_d == '0) : zero_q;
        neg_d  = load ? result_d[XLEN-1] : neg_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            work_q   <= '0;
            rem_q    <= '0;
            kind_q   <= ALU_SLL;
            result_q <= '0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q  <= state_d;
            work_q   <= work_d;
            rem_q    <= rem_d;
            kind_q   <= kind_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
        end
    end

endmodule

// File: tb/tb_seq_alu_unit.sv
// Self-checking bench for seq_alu_unit: directed cases plus randomized ops
// against a behavioural reference model.
module tb_seq_alu_unit;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;

    seq_alu_if #(.XLEN(32)) bus  ();
    seq_alu_if #(.XLEN(32)) bus2 ();

    seq_alu_unit #(.XLEN(32), .SHIFT_STEP(1)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    seq_alu_unit #(.XLEN(32), .SHIFT_STEP(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] ref_result(logic [1:0] op, logic [2:0] f3, logic o5, logic f7,
                                               logic [31:0] a, logic [31:0] b);
        int unsigned sh = 32'(b[4:0]);
        logic [31:0] slt  = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        logic [31:0] sltu = (a < b) ? 32'd1 : 32'd0;
        if (op == 2'b01) begin
            if (f3 == 3'b000 || f3 == 3'b001) return a - b;
            if (f3 == 3'b100 || f3 == 3'b101) return slt;
            if (f3 == 3'b110 || f3 == 3'b111) return sltu;
            return a + b;
        end
        if (op == 2'b10) begin
            case (f3)
                3'd0: return (o5 && f7) ? a - b : a + b;
                3'd1: return a << sh;
                3'd2: return slt;
                3'd3: return sltu;
                3'd4: return a ^ b;
                3'd5: return f7 ? 32'($signed(a) >>> sh) : a >> sh;
                3'd6: return a | b;
                default: return a & b;
            endcase
        end
        return a + b;
    endfunction

    function automatic int ref_latency(logic [1:0] op, logic [2:0] f3, logic [31:0] b, int step);
        int sh = int'(b[4:0]);
        if (op == 2'b10 && (f3 == 3'b001 || f3 == 3'b101) && sh != 0)
            return 1 + (sh + step - 1) / step;
        return 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op to the SHIFT_STEP=1 unit from idle, hold the result for
    // `stall` cycles, then retire it.
    task automatic do_op(input string tag, input logic [1:0] op, input logic [2:0] f3,
                         input logic o5, input logic f7, input logic [31:0] a,
                         input logic [31:0] b, input int stall);
        logic [31:0] exp;
        int lat, cyc;
        bit rdy_bad, unstable;
        exp = ref_result(op, f3, o5, f7, a, b);
        lat = ref_latency(op, f3, b, 1);
        bus.alu_op = op; bus.funct3 = f3; bus.op5 = o5; bus.funct7 = f7;
        bus.a = a; bus.b = b; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        check({tag, " in_ready idle"}, 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        bus.a = $urandom; bus.b = $urandom; bus.funct3 = 3'($urandom);
        cyc = 1; rdy_bad = 1'b0;
        while (!bus.out_valid && cyc < 100) begin
            if (bus.in_ready) rdy_bad = 1'b1;
            tick();
            cyc++;
        end
        check({tag, " latency"}, 32'(cyc), 32'(lat));
        check({tag, " in_ready busy"}, 32'(rdy_bad), 32'd0);
        check({tag, " result"}, bus.result, exp);
        check({tag, " zero"}, 32'(bus.zero), 32'(exp == 32'd0));
        check({tag, " neg"}, 32'(bus.neg), 32'(exp[31]));
        bus.in_valid = 1'b1;
        unstable = 1'b0;
        for (int i = 0; i < stall; i++) begin
            tick();
            if (!bus.out_valid || bus.result !== exp || bus.in_ready ||
                bus.zero !== (exp == 32'd0) || bus.neg !== exp[31]) unstable = 1'b1;
        end
        bus.in_valid = 1'b0;
        check({tag, " stable under stall"}, 32'(unstable), 32'd0);
        bus.out_ready = 1'b1;
        #1;
        check({tag, " in_ready on retire"}, 32'(bus.in_ready), 32'd1);
        tick();
        bus.out_ready = 1'b0;
        check({tag, " out_valid after retire"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] ra, rb, exp;
        logic [1:0]  rop;
        logic [2:0]  rf3;
        int          cyc;
        bit          stale;

        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.alu_op = 2'b00; bus.funct3 = 3'b000;
        bus.op5 = 1'b0; bus.funct7 = 1'b0; bus.a = '0; bus.b = '0;
        bus2.in_valid = 1'b0; bus2.out_ready = 1'b0; bus2.alu_op = 2'b00; bus2.funct3 = 3'b000;
        bus2.op5 = 1'b0; bus2.funct7 = 1'b0; bus2.a = '0; bus2.b = '0;
        repeat (2) tick();
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset result", bus.result, 32'd0);
        check("reset zero", 32'(bus.zero), 32'd0);
        check("reset neg", 32'(bus.neg), 32'd0);
        check("reset out_valid dut2", 32'(bus2.out_valid), 32'd0);
        rst_n = 1'b1;
        #1;
        check("in_ready after reset", 32'(bus.in_ready), 32'd1);

        // SUB then ADD issued back to back with out_ready held high
        bus.alu_op = 2'b10; bus.funct3 = 3'b000; bus.op5 = 1'b1; bus.funct7 = 1'b1;
        bus.a = 32'd5; bus.b = 32'd7; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        tick();
        check("b2b sub out_valid", 32'(bus.out_valid), 32'd1);
        check("b2b sub result", bus.result, 32'hFFFF_FFFE);
        check("b2b sub neg", 32'(bus.neg), 32'd1);
        check("b2b sub zero", 32'(bus.zero), 32'd0);
        check("b2b in_ready", 32'(bus.in_ready), 32'd1);
        bus.alu_op = 2'b00; bus.a = 32'd3; bus.b = 32'd4;
        tick();
        bus.in_valid = 1'b0;
        check("b2b add out_valid", 32'(bus.out_valid), 32'd1);
        check("b2b add result", bus.result, 32'd7);
        tick();
        bus.out_ready = 1'b0;
        check("b2b drained", 32'(bus.out_valid), 32'd0);

        do_op("sra4",       2'b10, 3'b101, 1'b1, 1'b1, 32'h8000_0000, 32'd4, 0);
        do_op("br slt",     2'b01, 3'b100, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 0);
        do_op("br sltu",    2'b01, 3'b110, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 0);
        do_op("br sub eq",  2'b01, 3'b000, 1'b0, 1'b0, 32'd9, 32'd9, 0);
        do_op("reserved",   2'b11, 3'b000, 1'b0, 1'b0, 32'd2, 32'd3, 0);
        do_op("sll0",       2'b10, 3'b001, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0000_0100, 0);
        do_op("srl31",      2'b10, 3'b101, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd31, 0);
        do_op("backpress",  2'b00, 3'b000, 1'b0, 1'b0, 32'h1234_5678, 32'h1111_1111, 3);

        // Reset in the middle of a long shift
        bus.alu_op = 2'b10; bus.funct3 = 3'b001; bus.op5 = 1'b0; bus.funct7 = 1'b0;
        bus.a = 32'd1; bus.b = 32'd20; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midshift rst out_valid", 32'(bus.out_valid), 32'd0);
        check("midshift rst result", bus.result, 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        check("post-rst in_ready", 32'(bus.in_ready), 32'd1);
        stale = 1'b0;
        repeat (30) begin
            tick();
            if (bus.out_valid) stale = 1'b1;
        end
        check("no stale out_valid", 32'(stale), 32'd0);

        // Two-bit-per-cycle instance
        for (int k = 0; k < 2; k++) begin
            ra = (k == 0) ? 32'h8000_0000 : 32'h0000_00F0;
            rb = (k == 0) ? 32'd4 : 32'd5;
            bus2.alu_op = 2'b10; bus2.funct3 = 3'b101; bus2.op5 = 1'b0;
            bus2.funct7 = (k == 0); bus2.a = ra; bus2.b = rb;
            exp = ref_result(2'b10, 3'b101, 1'b0, k == 0, ra, rb);
            bus2.in_valid = 1'b1; bus2.out_ready = 1'b0;
            tick();
            bus2.in_valid = 1'b0;
            cyc = 1;
            while (!bus2.out_valid && cyc < 100) begin
                tick();
                cyc++;
            end
            check("step2 latency", 32'(cyc), 32'(ref_latency(2'b10, 3'b101, rb, 2)));
            check("step2 result", bus2.result, exp);
            bus2.out_ready = 1'b1;
            tick();
            bus2.out_ready = 1'b0;
        end

        // Randomized ops against the reference model
        for (int n = 0; n < 40; n++) begin
            rop = 2'($urandom_range(0, 3));
            rf3 = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            do_op("rand", rop, rf3, 1'($urandom), 1'($urandom), ra, rb, $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/seq_alu_unit.md
# seq_alu_unit

Parametrised multi-cycle ALU for the next-generation core. It folds the ALU-control decode (alu_op/funct3/op5/funct7) into a datapath of width XLEN. The decoded set adds SLT/SLTU and arithmetic right shift. Shifts run iteratively, SHIFT_STEP bits per cycle. The unit sits between operand-read and writeback behind valid/ready handshakes on both sides, so a stalled writeback back-pressures issue.

## Interface
- XLEN, 32: datapath width; power of two, at least 8.
- SHIFT_STEP, 1: bits shifted per cycle; power of two, at most XLEN.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  unit can accept an operation this cycle.
- alu_op  in  2  00 load/store, 01 branch, 10 R/I arithmetic, 11 reserved.
- funct3  in  3  instruction funct3.
- op5  in  1  opcode bit 5 (1 = R-type).
- funct7  in  1  instruction funct7 bit 5.
- a, b  in  XLEN  operands. Shift amount is b[log2(XLEN)-1:0].
- out_valid  out  1  result held and valid.
- out_ready  in  1  consumer takes the result.
- result  out  XLEN  operation result.
- zero  out  1  result equals 0.
- neg  out  1  result[XLEN-1].

## Operation
- Decode (combinational):
  - alu_op 00 → ADD.
  - alu_op 01, by funct3: 000/001 → SUB; 100/101 → SLT; 110/111 → SLTU.
  - alu_op 10, by funct3:
    - 000 → SUB if op5 and funct7, else ADD.
    - 001 → SLL.
    - 010 → SLT.
    - 011 → SLTU.
    - 100 → XOR.
    - 101 → SRA if funct7, else SRL.
    - 110 → OR.
    - 111 → AND.
  - alu_op 11, and any unlisted code → ADD.
- Arithmetic:
  - ADD and SUB are modulo 2^XLEN; carry is discarded.
  - SLT and SLTU return 1 or 0, zero-extended to XLEN.
  - SRA replicates the operand MSB.
- FSM states:
  - IDLE, SHIFT, DONE; reset state is IDLE.
  - IDLE, on accept of a non-shift op or a shift with shamt 0: register the result and go to DONE.
  - IDLE, on accept of a shift with shamt > 0: load the working register with a and the remaining count with shamt, then go to SHIFT.
  - SHIFT: each cycle, shift by min(SHIFT_STEP, remaining) and decrement remaining by the same amount. When remaining reaches 0, go to DONE.
  - DONE: out_valid = 1. On out_ready, go to IDLE, or accept a new op in the same cycle (back-to-back issue).
- Accept condition: in_valid && in_ready.
- in_ready = (state == IDLE) || (state == DONE && out_ready). It is combinational and never depends on in_valid.
- Outputs:
  - result, zero and neg are registered.
  - They are stable while out_valid && !out_ready.
  - zero and neg are computed from the final result.
- Reset values: state IDLE, out_valid 0, result 0, zero 0, neg 0, remaining count 0. in_ready is 1 while rst_n is high and the state is IDLE.
- Reset asserted mid-SHIFT or in DONE aborts the operation; the result is lost and no out_valid pulse follows.
- The unit captures inputs only on accept. Operand changes at any other time have no effect.

## Timing
- Accept at edge T.
- Non-shift op, or shift with shamt 0: out_valid is high from T+1.
- Shift with shamt > 0: out_valid is high from T+1+ceil(shamt/SHIFT_STEP).
- Defaults (XLEN 32, SHIFT_STEP 1): worst case is shamt 31 → 32 cycles.
- Throughput: one non-shift op per cycle while out_ready is held high.
- out_valid stays high until the cycle in which out_ready is sampled high. It deasserts the next cycle unless a new non-shift op was accepted in that same cycle.
- No combinational path from in_valid, a or b to any output. out_ready → in_ready is the only combinational path.

## Structure
- Package seq_alu_pkg:
  - alu_ctrl_e, a 4-bit enum: ADD, SUB, SLL, SRL, SRA, XOR, OR, AND, SLT, SLTU.
  - alu_op encodings.
  - FSM state enum.
- Sub-module alu_ctrl_decode: purely combinational (alu_op, funct3, op5, funct7 → alu_ctrl_e), reusable by the single-cycle core.
- Top level holds the FSM, the working/shift register, the remaining-count register and the result flags.

## Test plan
- SUB, back-to-back issue: alu_op 10, funct3 000, op5 1, funct7 1, a 5, b 7, out_ready high → result 0xFFFFFFFE, neg 1, zero 0, out_valid at T+1. A second ADD (3+4) accepted the same cycle → result 7 at T+2.
- SRA, SHIFT_STEP 1: a 0x80000000, b 4 → result 0xF8000000, out_valid at T+5, in_ready low from T+1 to T+4. Repeat with SHIFT_STEP 2 → out_valid at T+3.
- Branch decode: alu_op 01, funct3 100, a 0xFFFFFFFF, b 1 → result 1 (SLT). Same operands with funct3 110 → result 0 (SLTU). With funct3 000 and a = b = 9 → zero 1.
- Backpressure: ADD completes with out_ready low for 3 cycles → result, zero and neg are stable, out_valid stays 1, in_ready stays 0, and in_valid is ignored. Release out_ready → one transfer only.
- Reset mid-shift: SLL a 1, b 20; assert rst_n low at T+6 → out_valid 0, result 0 immediately. After release, in_ready is 1 and no stale result appears.
- Reserved and edge cases:
  - alu_op 11, a 2, b 3 → result 5.
  - SLL with shamt 0 → result a at T+1.
  - SRL a 0xFFFFFFFF, b 31 → result 1.
